fmdll_div_counter: RTL and testbench
====================================

// Module: fmdll_div_counter
// PURPOSE
//  Upstream counter/divider stage of the FMDLL select path. Counts CLK edges modulo (N+1)
//  and counts N-periods modulo (M+1); these form one frame.
//  Drives N_counter, M_counter, DIV_N and DIV_M into the select logic, which uses the
//  terminal counts to choose the injection path.
//  Latches N and M into shadow registers only at frame boundaries, so ratio changes are
//  glitch-free.
// PARAMETERS
//  NW  4  width of N / N_counter
//  MW  2  width of M / M_counter
// PORTS
//  CLK        in   1   sole clock; multiplied DLL output clock
//  RST_n      in   1   asynchronous, active-low reset
//  EN         in   1   run request; level-sensitive
//  N          in   NW  N-period terminal count; 0 is treated as 1
//  M          in   MW  frame terminal count (N-periods per frame minus 1)
//  N_counter  out  NW  current count within the N-period, 0..N_r
//  M_counter  out  MW  current N-period within the frame, 0..M_r
//  DIV_N      out  1   divided clock, period N_r+1 CLKs
//  DIV_M      out  1   frame marker, high only in the first half of N-period 0
//  FRAME      out  1   1-cycle pulse on the last CLK of each frame
//  RUNNING    out  1   high while in RUN
// BEHAVIOUR
//  Outputs and reset
//   - All outputs are registered.
//   - RST_n low (async) clears: state=IDLE, N_r=1, M_r=0, all outputs 0.
//  FSM IDLE -> LOAD -> RUN -> IDLE
//   - IDLE: counters held at 0; DIV_N/DIV_M/FRAME/RUNNING low.
//     Moves to LOAD when EN=1.
//   - LOAD (1 cycle): N_r <= (N==0 ? 1 : N); M_r <= M; counters 0.
//     Always moves to RUN; RUNNING goes high entering RUN.
//   - RUN: N_counter increments every CLK.
//     - Terminal N (N_counter==N_r): N_counter <= 0; M_counter increments,
//       or wraps to 0 when M_counter==M_r.
//     - Frame end (N_counter==N_r && M_counter==M_r): FRAME=1 for that cycle.
//       N_r/M_r resample N/M (same clamp).
//       If EN=0, next state is IDLE (graceful stop: frames never truncated); else stay in RUN.
//   - EN falling mid-frame: ignored until frame end.
//     EN re-asserted before frame end: no stop.
//  Divided outputs
//   - DIV_N = 1 iff next N_counter < (N_r+2)>>1.
//     Example: N_r=3 gives 1,1,0,0. DIV_N is therefore 0 at N_counter==N_r.
//   - DIV_M = DIV_N & (next M_counter==0). DIV_M is therefore 0 at every terminal
//     N_counter==N_r, and in particular when M_counter==M_r.
//  Timing and edge cases
//   - Latency: EN high at edge k -> LOAD at k+1 -> first RUN cycle (N_counter=0,
//     DIV_N=1) at k+2.
//   - Mid-frame changes on N/M have no effect until the next frame end.
//   - M_r=0: every N-period is a frame; FRAME pulses each N-period.
//   - Counters never exceed their shadow terminal values; no overflow wrap beyond N_r/M_r.
// STRUCTURE
//  - fmdll_pkg holds: the state enum {IDLE, LOAD, RUN}, the NW/MW defaults, and the
//    N-clamp function.
//  - Sub-module fmdll_mod_counter: width-parameterised counter with enable, terminal input
//    and wrap flag. Instantiated twice (N counter, M counter chained on the N wrap).
//  - Top level holds the FSM, shadow registers, and DIV/FRAME logic.
// TESTING
//  - Reset mid-RUN (N=5, M=2): drop RST_n asynchronously between edges
//    -> all outputs 0 immediately; state=IDLE.
//  - N=3, M=2, EN=1
//    -> N_counter 0,1,2,3 repeating; M_counter steps 0,1,2; DIV_N 1100;
//       FRAME every 12 CLKs; DIV_M high in CLKs 0-1 of each frame only.
//  - N=0, M=0
//    -> clamped to N_r=1: N_counter 0,1; DIV_N 1,0; FRAME every 2 CLKs.
//  - Change N 3->7 at CLK 5 of a frame (N=3, M=1)
//    -> current frame completes with N_r=3 (8 CLKs); next frame uses N_r=7.
//  - EN deasserted at CLK 2 of frame (N=2, M=1)
//    -> runs to CLK 5 with FRAME=1, then IDLE; RUNNING low; counters 0.
//  - Every RUN cycle with N_counter==N_r: assert DIV_N==0; if also M_counter==M_r,
//    assert DIV_M==0.

Source files
------------

// File: rtl/fmdll_div_counter_pkg.sv
// Shared types, default widths and the N-clamp helper for the FMDLL divider/counter stage.
package fmdll_pkg;

  localparam int unsigned NW_DEF = 4;
  localparam int unsigned MW_DEF = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_e;

  // A zero N-period count would stall the divider, so it is promoted to 1.
  function automatic logic [31:0] clamp_n(input logic [31:0] n);
    return (n == 32'd0) ? 32'd1 : n;
  endfunction

endpackage

// File: rtl/fmdll_div_counter_if.sv
// Control inputs and counter/divider outputs between the FMDLL divider and its consumers.
interface fmdll_div_counter_if
  import fmdll_pkg::*;
#(
  parameter int unsigned NW = NW_DEF,
  parameter int unsigned MW = MW_DEF
);

  logic          EN;
  logic [NW-1:0] N;
  logic [MW-1:0] M;
  logic [NW-1:0] N_counter;
  logic [MW-1:0] M_counter;
  logic          DIV_N;
  logic          DIV_M;
  logic          FRAME;
  logic          RUNNING;

  modport master (
    output EN, N, M,
    input  N_counter, M_counter, DIV_N, DIV_M, FRAME, RUNNING
  );

  modport slave (
    input  EN, N, M,
    output N_counter, M_counter, DIV_N, DIV_M, FRAME, RUNNING
  );

endinterface

// File: rtl/fmdll_div_counter_mod_counter.sv
// Modulo (term+1) counter with sync clear, enable, registered count and look-ahead next value.
module fmdll_mod_counter #(
  parameter int unsigned W = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_term,
  output logic [W-1:0] o_count,
  output logic [W-1:0] o_next_c,
  output logic         o_wrap_c
);

  logic [W-1:0] r_count;

  always_comb begin
    o_wrap_c = 1'b0;
    o_next_c = r_count;
    if (i_clr) begin
      o_next_c = '0;
    end else if (i_en) begin
      o_wrap_c = (r_count == i_term);
      o_next_c = o_wrap_c ? '0 : r_count + W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_count <= '0;
    else          r_count <= o_next_c;
  end

  assign o_count = r_count;

endmodule

// File: rtl/fmdll_div_counter.sv
// FMDLL select-path front end: N/M frame counters, shadowed ratio, divided clock and frame marker.
module fmdll_div_counter
  import fmdll_pkg::*;
#(
  parameter int unsigned NW = NW_DEF,
  parameter int unsigned MW = MW_DEF
) (
  input  logic CLK,
  input  logic RST_n,
  fmdll_div_counter_if.slave bus
);

  localparam int unsigned NW1 = NW + 1;

  state_e        r_state;
  state_e        w_state_next;
  logic [NW-1:0] r_nr;
  logic [NW-1:0] w_nr_next;
  logic [MW-1:0] r_mr;
  logic [MW-1:0] w_mr_next;
  logic          w_load_shadow;
  logic          w_run;
  logic          w_cnt_clr;

  logic [NW-1:0] w_ncnt;
  logic [NW-1:0] w_ncnt_next;
  logic          w_n_wrap;
  logic [MW-1:0] w_mcnt;
  logic [MW-1:0] w_mcnt_next;
  logic          w_m_wrap;

  logic [NW1-1:0] w_half;
  logic           w_run_next;
  logic           w_div_n_next;
  logic           w_div_m_next;
  logic           w_frame_next;

  logic r_div_n;
  logic r_div_m;
  logic r_frame;
  logic r_running;

  assign w_run     = (r_state == RUN);
  assign w_cnt_clr = !w_run;

  fmdll_mod_counter #(.W(NW)) u_n_cnt (
    .i_clk    (CLK),
    .i_rst_n  (RST_n),
    .i_clr    (w_cnt_clr),
    .i_en     (w_run),
    .i_term   (r_nr),
    .o_count  (w_ncnt),
    .o_next_c (w_ncnt_next),
    .o_wrap_c (w_n_wrap)
  );

  // M counter advances once per completed N-period; its wrap marks the frame end.
  fmdll_mod_counter #(.W(MW)) u_m_cnt (
    .i_clk    (CLK),
    .i_rst_n  (RST_n),
    .i_clr    (w_cnt_clr),
    .i_en     (w_n_wrap),
    .i_term   (r_mr),
    .o_count  (w_mcnt),
    .o_next_c (w_mcnt_next),
    .o_wrap_c (w_m_wrap)
  );

  always_comb begin
    w_state_next  = r_state;
    w_load_shadow = 1'b0;
    w_nr_next     = r_nr;
    w_mr_next     = r_mr;
    case (r_state)
      IDLE: if (bus.EN) w_state_next = LOAD;
      LOAD: begin
        w_load_shadow = 1'b1;
        w_state_next  = RUN;
      end
      RUN: begin
        // Stop requests only take effect at a frame boundary.
        if (w_m_wrap) begin
          w_load_shadow = 1'b1;
          if (!bus.EN) w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
    if (w_load_shadow) begin
      w_nr_next = NW'(clamp_n(32'(bus.N)));
      w_mr_next = bus.M;
    end
  end

  // Registered outputs are derived from next-cycle counter and shadow values.
  always_comb begin
    w_run_next   = (w_state_next == RUN);
    w_half       = (NW1'(w_nr_next) + NW1'(2)) >> 1;
    w_div_n_next = w_run_next && (NW1'(w_ncnt_next) < w_half);
    w_div_m_next = w_div_n_next && (w_mcnt_next == '0);
    w_frame_next = w_run_next && (w_ncnt_next == w_nr_next) && (w_mcnt_next == w_mr_next);
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_state   <= IDLE;
      r_nr      <= NW'(1);
      r_mr      <= '0;
      r_div_n   <= 1'b0;
      r_div_m   <= 1'b0;
      r_frame   <= 1'b0;
      r_running <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_nr      <= w_nr_next;
      r_mr      <= w_mr_next;
      r_div_n   <= w_div_n_next;
      r_div_m   <= w_div_m_next;
      r_frame   <= w_frame_next;
      r_running <= w_run_next;
    end
  end

  assign bus.N_counter = w_ncnt;
  assign bus.M_counter = w_mcnt;
  assign bus.DIV_N     = r_div_n;
  assign bus.DIV_M     = r_div_m;
  assign bus.FRAME     = r_frame;
  assign bus.RUNNING   = r_running;

endmodule

// File: tb/tb_fmdll_div_counter.sv
// Directed checks of fmdll_div_counter: reset, run sequences, clamping, ratio shadowing, graceful stop.
module tb_fmdll_div_counter;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  fmdll_div_counter_if bus ();

  fmdll_div_counter dut (
    .CLK   (clk),
    .RST_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input int ncnt, input int mcnt, input int dn,
                           input int dm, input int fr, input int rn);
    check({tag, ".N_counter"}, 32'(bus.N_counter), 32'(ncnt));
    check({tag, ".M_counter"}, 32'(bus.M_counter), 32'(mcnt));
    check({tag, ".DIV_N"},     32'(bus.DIV_N),     32'(dn));
    check({tag, ".DIV_M"},     32'(bus.DIV_M),     32'(dm));
    check({tag, ".FRAME"},     32'(bus.FRAME),     32'(fr));
    check({tag, ".RUNNING"},   32'(bus.RUNNING),   32'(rn));
  endtask

  // Called on a negedge; returns on the negedge of the first RUN cycle.
  task automatic start_run(input string tag, input int n, input int m);
    bus.N  = 4'(n);
    bus.M  = 2'(m);
    bus.EN = 1'b1;
    @(negedge clk);
    check_all({tag, ".load"}, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
  endtask

  task automatic stop_run(input string tag);
    bit done;
    done   = 1'b0;
    bus.EN = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (!bus.RUNNING) done = 1'b1;
    end
    check({tag, ".stop_reached"}, 32'(done), 32'd1);
    check_all({tag, ".idle"}, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    bus.EN   = 1'b0;
    bus.N    = '0;
    bus.M    = '0;
    rst_n    = 1'b1;
    #1 rst_n = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check_all("reset", 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check_all("idle_after_reset", 0, 0, 0, 0, 0, 0);

    // N=3, M=2: 12-CLK frames
    start_run("n3m2", 3, 2);
    for (int j = 0; j < 24; j++) begin
      int nc, mc, dn;
      if (j > 0) @(negedge clk);
      nc = j % 4;
      mc = (j / 4) % 3;
      dn = (nc < 2) ? 1 : 0;
      check_all($sformatf("n3m2[%0d]", j), nc, mc, dn, (dn == 1 && mc == 0) ? 1 : 0,
                (j % 12 == 11) ? 1 : 0, 1);
    end
    stop_run("n3m2");

    // N=0 clamps to 1, M=0: frame every two CLKs
    start_run("n0m0", 0, 0);
    for (int j = 0; j < 8; j++) begin
      int dn;
      if (j > 0) @(negedge clk);
      dn = (j % 2 == 0) ? 1 : 0;
      check_all($sformatf("n0m0[%0d]", j), j % 2, 0, dn, dn, (j % 2 == 1) ? 1 : 0, 1);
    end
    stop_run("n0m0");

    // N changed 3->7 mid-frame takes effect only at the next frame
    start_run("nchg", 3, 1);
    for (int j = 0; j < 24; j++) begin
      int nc, mc, dn, fr;
      if (j > 0) @(negedge clk);
      if (j < 8) begin
        nc = j % 4;
        mc = j / 4;
        dn = (nc < 2) ? 1 : 0;
        fr = (j == 7) ? 1 : 0;
      end else begin
        nc = (j - 8) % 8;
        mc = (j - 8) / 8;
        dn = (nc < 4) ? 1 : 0;
        fr = (j == 23) ? 1 : 0;
      end
      check_all($sformatf("nchg[%0d]", j), nc, mc, dn, (dn == 1 && mc == 0) ? 1 : 0, fr, 1);
      if (j == 5) bus.N = 4'd7;
    end
    stop_run("nchg");

    // EN dropped mid-frame: frame completes, then IDLE
    start_run("stop", 2, 1);
    for (int j = 0; j < 6; j++) begin
      int nc, mc, dn;
      if (j > 0) @(negedge clk);
      nc = j % 3;
      mc = j / 3;
      dn = (nc < 2) ? 1 : 0;
      check_all($sformatf("stop[%0d]", j), nc, mc, dn, (dn == 1 && mc == 0) ? 1 : 0,
                (j == 5) ? 1 : 0, 1);
      if (j == 2) bus.EN = 1'b0;
    end
    @(negedge clk);
    check_all("stop.after", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check_all("stop.held", 0, 0, 0, 0, 0, 0);

    // Asynchronous reset in the middle of a RUN frame
    start_run("arst", 5, 2);
    for (int j = 0; j < 7; j++) begin
      int nc, mc, dn;
      if (j > 0) @(negedge clk);
      nc = j % 6;
      mc = j / 6;
      dn = (nc < 3) ? 1 : 0;
      check_all($sformatf("arst[%0d]", j), nc, mc, dn, (dn == 1 && mc == 0) ? 1 : 0, 0, 1);
    end
    #2 rst_n = 1'b0;
    #1;
    check_all("arst.immediate", 0, 0, 0, 0, 0, 0);
    bus.EN = 1'b0;
    @(negedge clk);
    check_all("arst.held", 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check_all("arst.released", 0, 0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
